fft_sequencer: RTL and testbench

Issue-side controller for the in-place radix-2 FFT datapath. On a start pulse it walks every stage (0 to log2(N)-1) and every butterfly pair (0 to N/2-1), presenting one {stage, pair_id} with a valid strobe per cycle to the address generation unit. Between stages it inserts a fixed drain gap so that write-backs from the previous stage land in sample memory before the next stage reads. It signals completion with a one-cycle done pulse.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_drain_timer.sv | 36 +++
 rtl/fft_sequencer.sv | 145 ++++++++++++++
 tb/tb_fft_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default transform size, field widths and the
// issue-sequencer state encoding, used by the sequencer, AGU and butterfly.
package fft_pkg;

    localparam int N_DEFAULT     = 32;
    localparam int DRAIN_DEFAULT = 4;
    localparam int LOG2N         = $clog2(N_DEFAULT);
    localparam int STAGE_WIDTH   = $clog2(LOG2N);
    localparam int PAIR_ID_WIDTH = $clog2(N_DEFAULT / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } fsm_state_e;

    // Drain counter width: enough to hold DRAIN, never narrower than 1 bit.
    function automatic int drain_cnt_width(input int drain);
        return (drain > 0) ? $clog2(drain + 1) : 1;
    endfunction

endpackage

// File: rtl/fft_drain_timer.sv
// Loadable down-counter with an expiry flag.
// Ports: clk, reset (async, active-high), i_load/i_value load the count,
// o_expired is high while the count is zero. Counts down one per cycle.
module fft_drain_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = (count_q == '0);

endmodule

// File: rtl/fft_sequencer.sv
// Issue-side controller for the in-place radix-2 FFT: walks every stage and
// butterfly pair, one {stage, pair_id} per cycle, with a drain gap between
// stages and a one-cycle done pulse at the end.
// Ports: clk, reset (async, active-high), i_start, i_hold (back-pressure);
// stage, pair_id, o_valid to the AGU; o_busy, o_done status. All registered.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int N             = N_DEFAULT,
    parameter int DRAIN         = DRAIN_DEFAULT,
    parameter int stage_width   = $clog2($clog2(N)),
    parameter int pair_id_width = $clog2(N / 2)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic                     i_hold,
    output logic [stage_width-1:0]   stage,
    output logic [pair_id_width-1:0] pair_id,
    output logic                     o_valid,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int TW = drain_cnt_width(DRAIN);
    localparam logic [stage_width-1:0]   LAST_STAGE = stage_width'($clog2(N) - 1);
    localparam logic [pair_id_width-1:0] LAST_PAIR  = pair_id_width'(N / 2 - 1);
    localparam logic [TW-1:0]            DRAIN_LOAD = TW'(DRAIN);

    fsm_state_e state_q, state_d;

    // stage_q doubles as the stage counter; pair_q is the next pair to issue.
    logic [stage_width-1:0]   stage_q, stage_d;
    logic [pair_id_width-1:0] pair_id_q, pair_id_d;
    logic [pair_id_width-1:0] pair_q, pair_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     issue;
    logic [stage_width-1:0]   iss_stage;
    logic [pair_id_width-1:0] iss_pair;
    logic                     tmr_load;
    logic                     tmr_expired;

    fft_drain_timer #(
        .WIDTH(TW)
    ) u_drain_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (tmr_load),
        .i_value  (DRAIN_LOAD),
        .o_expired(tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        pair_id_d = pair_id_q;
        pair_d    = pair_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        issue     = 1'b0;
        iss_stage = stage_q;
        iss_pair  = pair_q;

        // Entering a stage (from IDLE or on drain expiry) issues pair 0 in the
        // same edge, so the first pair of a stage costs no extra cycle.
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    issue     = 1'b1;
                    iss_stage = '0;
                    iss_pair  = '0;
                end
            end
            S_ISSUE: begin
                if (!i_hold) begin
                    issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (tmr_expired) begin
                    if (stage_q == LAST_STAGE) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        issue     = 1'b1;
                        iss_stage = stage_q + 1'b1;
                        iss_pair  = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The last pair of a stage always passes through DRAIN; with DRAIN=0
        // the timer is already expired there, which is the stage-advance edge.
        if (issue) begin
            valid_d   = 1'b1;
            stage_d   = iss_stage;
            pair_id_d = iss_pair;
            if (iss_pair == LAST_PAIR) begin
                pair_d   = '0;
                state_d  = S_DRAIN;
                tmr_load = 1'b1;
            end else begin
                pair_d  = iss_pair + 1'b1;
                state_d = S_ISSUE;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            stage_q   <= '0;
            pair_id_q <= '0;
            pair_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            pair_id_q <= pair_id_d;
            pair_q    <= pair_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign stage   = stage_q;
    assign pair_id = pair_id_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer: three instances (N=32/DRAIN=4,
// N=32/DRAIN=0, N=8/DRAIN=2 with an AGU address model).
module tb_fft_sequencer;

    typedef struct {
        bit done;
        int stg;
        int pair;
        int cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qz[$];
    exp_t qs[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit [7:0] seen = '0;

    logic       a_start = 1'b0, a_hold = 1'b0;
    logic [2:0] a_stage;
    logic [3:0] a_pair;
    logic       a_valid, a_busy, a_done;

    logic       z_start = 1'b0, z_hold = 1'b0;
    logic [2:0] z_stage;
    logic [3:0] z_pair;
    logic       z_valid, z_busy, z_done;

    logic       s_start = 1'b0, s_hold = 1'b0;
    logic [1:0] s_stage;
    logic [1:0] s_pair;
    logic       s_valid, s_busy, s_done;

    fft_sequencer #(.N(32), .DRAIN(4)) dut_a (
        .clk(clk), .reset(rst), .i_start(a_start), .i_hold(a_hold),
        .stage(a_stage), .pair_id(a_pair), .o_valid(a_valid),
        .o_busy(a_busy), .o_done(a_done)
    );

    fft_sequencer #(.N(32), .DRAIN(0)) dut_z (
        .clk(clk), .reset(rst), .i_start(z_start), .i_hold(z_hold),
        .stage(z_stage), .pair_id(z_pair), .o_valid(z_valid),
        .o_busy(z_busy), .o_done(z_done)
    );

    fft_sequencer #(.N(8), .DRAIN(2)) dut_s (
        .clk(clk), .reset(rst), .i_start(s_start), .i_hold(s_hold),
        .stage(s_stage), .pair_id(s_pair), .o_valid(s_valid),
        .o_busy(s_busy), .o_done(s_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input int which, input exp_t e);
        case (which)
            0: qa.push_back(e);
            1: qz.push_back(e);
            default: qs.push_back(e);
        endcase
    endtask

    // Expected issue/done timeline of one transform started at cycle t.
    // A hold of hn cycles at (hs, hp) shifts that pair and all later events.
    // Events at or after cycle 'stop' are not expected (aborted run).
    task automatic push_run(input int which, input int t, input int n,
                            input int d, input int hs, input int hp,
                            input int hn, input int stop);
        int   l;
        int   sh;
        exp_t e;
        l = $clog2(n);
        for (int s = 0; s < l; s++) begin
            for (int p = 0; p < n / 2; p++) begin
                sh = (s > hs || (s == hs && p >= hp)) ? hn : 0;
                e = '{1'b0, s, p, t + 1 + s * (n / 2 + d) + p + sh};
                if (e.cyc < stop) push(which, e);
            end
        end
        e = '{1'b1, 0, 0, t + 1 + l * (n / 2 + d) + hn};
        if (e.cyc < stop) push(which, e);
    endtask

    task automatic check_ev(input int which, input bit done, input int stg,
                            input int pair, input bit busy);
        exp_t e;
        bit   got;
        got = 1'b0;
        e = '{1'b0, 0, 0, 0};
        case (which)
            0: if (qa.size() > 0) begin e = qa.pop_front(); got = 1'b1; end
            1: if (qz.size() > 0) begin e = qz.pop_front(); got = 1'b1; end
            default: if (qs.size() > 0) begin e = qs.pop_front(); got = 1'b1; end
        endcase
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL unexpected_event dut%0d: done=%0b stage=%0d pair=%0d cycle=%0d, expected no event",
                     which, done, stg, pair, cyc);
        end else if (e.done != done || e.stg != stg || e.pair != pair || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL event dut%0d: got done=%0b stage=%0d pair=%0d cycle=%0d, expected done=%0b stage=%0d pair=%0d cycle=%0d",
                     which, done, stg, pair, cyc, e.done, e.stg, e.pair, e.cyc);
        end
        chk(done ? "busy_in_done" : "busy_in_issue", int'(busy), done ? 0 : 1);
    endtask

    // Reference in-place radix-2 address pair for N=8.
    task automatic agu_cover(input int s, input int p);
        int half;
        int a;
        int b;
        half = 1 << s;
        a = (p >> s) * (2 * half) + (p & (half - 1));
        b = a + half;
        chk("agu_a_fresh", int'(seen[a]), 0);
        seen[a] = 1'b1;
        chk("agu_b_fresh", int'(seen[b]), 0);
        seen[b] = 1'b1;
        if (p == 3) begin
            chk("agu_stage_cover", int'(seen), 255);
            seen = '0;
        end
    endtask

    always @(negedge clk) begin
        if (a_valid) check_ev(0, 1'b0, int'(a_stage), int'(a_pair), a_busy);
        if (a_done)  check_ev(0, 1'b1, 0, 0, a_busy);
        if (z_valid) check_ev(1, 1'b0, int'(z_stage), int'(z_pair), z_busy);
        if (z_done)  check_ev(1, 1'b1, 0, 0, z_busy);
        if (s_valid) begin
            check_ev(2, 1'b0, int'(s_stage), int'(s_pair), s_busy);
            agu_cover(int'(s_stage), int'(s_pair));
        end
        if (s_done)  check_ev(2, 1'b1, 0, 0, s_busy);
    end

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, int'(a_valid), 0);
        chk({tag, "_busy"},  int'(a_busy),  0);
        chk({tag, "_done"},  int'(a_done),  0);
        chk({tag, "_stage"}, int'(a_stage), 0);
        chk({tag, "_pair"},  int'(a_pair),  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int t2;
        int t3;

        wait_cyc(2);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Run 1: nominal on all three instances, with ignored mid-run starts.
        t0 = 10;
        wait_cyc(t0);
        a_start = 1'b1;
        z_start = 1'b1;
        s_start = 1'b1;
        push_run(0, t0, 32, 4, 99, 0, 0, 1 << 30);
        push_run(1, t0, 32, 0, 99, 0, 0, 1 << 30);
        push_run(2, t0, 8, 2, 99, 0, 0, 1 << 30);
        chk("busy_before_start", int'(a_busy), 0);
        @(negedge clk);
        a_start = 1'b0;
        z_start = 1'b0;
        s_start = 1'b0;
        chk("busy_a_after_start", int'(a_busy), 1);
        chk("busy_z_after_start", int'(z_busy), 1);
        wait_cyc(t0 + 30);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_cyc(t0 + 95);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;

        // Run 2: started in the done cycle, with hold in ISSUE and in DRAIN.
        t1 = t0 + 101;
        wait_cyc(t1);
        chk("done_cycle_a", int'(a_done), 1);
        a_start = 1'b1;
        push_run(0, t1, 32, 4, 2, 7, 3, 1 << 30);
        @(negedge clk);
        a_start = 1'b0;
        wait_cyc(t1 + 47);
        a_hold = 1'b1;
        wait_cyc(t1 + 50);
        a_hold = 1'b0;
        wait_cyc(t1 + 80);
        a_hold = 1'b1;
        wait_cyc(t1 + 84);
        a_hold = 1'b0;

        // Run 3: aborted by reset during stage 3.
        t2 = t1 + 109;
        wait_cyc(t2);
        a_start = 1'b1;
        push_run(0, t2, 32, 4, 99, 0, 0, t2 + 70);
        @(negedge clk);
        a_start = 1'b0;
        wait_cyc(t2 + 69);
        chk("stage_before_abort", int'(a_stage), 3);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        wait_cyc(t2 + 72);
        rst = 1'b0;

        // Run 4: full transform after the abort.
        t3 = t2 + 75;
        wait_cyc(t3);
        a_start = 1'b1;
        push_run(0, t3, 32, 4, 99, 0, 0, 1 << 30);
        @(negedge clk);
        a_start = 1'b0;
        wait_cyc(t3 + 101);
        chk("done_after_abort", int'(a_done), 1);
        wait_cyc(t3 + 106);

        chk("queue_a_left", qa.size(), 0);
        chk("queue_z_left", qz.size(), 0);
        chk("queue_s_left", qs.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
